// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-master round-robin arbiter in front of a single SDRAM controller slave.
// Master 0 is the instruction cache, master 1 the data cache. One command is
// granted at a time; read tags are queued so returning read data can be
// steered back to the master that issued the read.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   m0_*/m1_*             master-side bus (address, read, write, writedata,
//                         byteenable in; waitrequest, readdata, readdatavalid out)
//   s_*                   slave-side bus toward the SDRAM controller
//   outstanding           number of reads accepted but not yet returned
//   err_rdv               sticky: read data arrived with no read outstanding
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no grant; requests sampled and owner chosen on the next edge
// BUSY  | owner's command driven to the slave until accepted or withdrawn
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic [ADDR_W-1:0]        m0_address,
    input  logic                     m0_read,
    input  logic                     m0_write,
    input  logic [DATA_W-1:0]        m0_writedata,
    input  logic [DATA_W/8-1:0]      m0_byteenable,
    output logic                     m0_waitrequest,
    output logic [DATA_W-1:0]        m0_readdata,
    output logic                     m0_readdatavalid,

    input  logic [ADDR_W-1:0]        m1_address,
    input  logic                     m1_read,
    input  logic                     m1_write,
    input  logic [DATA_W-1:0]        m1_writedata,
    input  logic [DATA_W/8-1:0]      m1_byteenable,
    output logic                     m1_waitrequest,
    output logic [DATA_W-1:0]        m1_readdata,
    output logic                     m1_readdatavalid,

    output logic [ADDR_W-1:0]        s_address,
    output logic                     s_read,
    output logic                     s_write,
    output logic [DATA_W-1:0]        s_writedata,
    output logic [DATA_W/8-1:0]      s_byteenable,
    input  logic                     s_waitrequest,
    input  logic [DATA_W-1:0]        s_readdata,
    input  logic                     s_readdatavalid,

    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_rdv
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic               owner;
    logic               last;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               tag_mem [MAX_OUT];

    logic               busy;
    logic               not_full;
    logic               req0;
    logic               req1;
    logic               own_read;
    logic               own_write;
    logic               accept;
    logic               push;
    logic               pop;
    logic               head;

    assign busy     = (state == BUSY);
    assign not_full = (count < FULL_CNT);
    assign req0     = m0_write | (m0_read & not_full);
    assign req1     = m1_write | (m1_read & not_full);

    assign own_read  = owner ? m1_read  : m0_read;
    assign own_write = owner ? m1_write : m0_write;

    assign s_read       = busy & own_read;
    assign s_write      = busy & own_write;
    assign s_address    = busy ? (owner ? m1_address    : m0_address)    : '0;
    assign s_writedata  = busy ? (owner ? m1_writedata  : m0_writedata)  : '0;
    assign s_byteenable = busy ? (owner ? m1_byteenable : m0_byteenable) : '0;

    assign m0_waitrequest = ~(busy & ~owner & ~s_waitrequest);
    assign m1_waitrequest = ~(busy &  owner & ~s_waitrequest);

    assign accept = busy & (s_read | s_write) & ~s_waitrequest;
    assign push   = accept & s_read;
    // Read data with no tag queued is dropped rather than steered anywhere.
    assign pop    = s_readdatavalid & (count != '0);
    assign head   = tag_mem[rd_ptr];

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop &  head;

    assign outstanding = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        owner <= ~last;
                        state <= BUSY;
                    end else if (req0) begin
                        owner <= 1'b0;
                        state <= BUSY;
                    end else if (req1) begin
                        owner <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant is held through any length of slave stall.
                    if (accept) begin
                        last  <= owner;
                        state <= IDLE;
                    end else if (!own_read && !own_write) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_rdv <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (s_readdatavalid && count == '0) err_rdv <= 1'b1;
        end
    end

    // Tag storage needs no reset: stale entries are never read past the pointers.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= owner;
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single read round trip, round-robin writes,
// stalled grant, full tag FIFO, read-data steering order, reset with reads
// in flight.
module tb_sdram_arbiter;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;

    logic               clk;
    logic               reset_n;
    logic [ADDR_W-1:0]  m0_address, m1_address, s_address;
    logic               m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0]  m0_writedata, m1_writedata, s_writedata;
    logic [3:0]         m0_byteenable, m1_byteenable, s_byteenable;
    logic               m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata, s_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic               s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [2:0]         outstanding;
    logic               err_rdv;

    int total = 0;
    int bad   = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .outstanding(outstanding), .err_rdv(err_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1;
        idle_inputs();
        do_reset();

        // reset state
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_rdv, 0);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_s_addr", s_address, 0);

        // single m0 read round trip
        @(negedge clk); m0_read = 1; m0_address = 23'h100; m0_byteenable = 4'hF; #1;
        check("rd_c1_s_read", s_read, 0);
        @(negedge clk); #1;
        check("rd_c2_s_read", s_read, 1);
        check("rd_c2_addr", s_address, 23'h100);
        check("rd_c2_m0_wait", m0_waitrequest, 0);
        check("rd_c2_m1_wait", m1_waitrequest, 1);
        @(negedge clk); m0_read = 0; #1;
        check("rd_out1", outstanding, 1);
        s_readdatavalid = 1; s_readdata = 32'hDEADBEEF; #1;
        check("rd_m0_rdv", m0_readdatavalid, 1);
        check("rd_m1_rdv", m1_readdatavalid, 0);
        check("rd_m0_data", m0_readdata, 32'hDEADBEEF);
        check("rd_m1_data", m1_readdata, 32'hDEADBEEF);
        @(negedge clk); s_readdatavalid = 0; #1;
        check("rd_out0", outstanding, 0);
        check("rd_m0_rdv_low", m0_readdatavalid, 0);
        check("rd_err", err_rdv, 0);

        // round-robin continuous writes
        do_reset();
        @(negedge clk);
        m0_write = 1; m0_address = 23'h0A0; m0_writedata = 32'h0000_00AA; m0_byteenable = 4'h3;
        m1_write = 1; m1_address = 23'h0B0; m1_writedata = 32'h0000_00BB; m1_byteenable = 4'hC;
        for (int i = 0; i < 8; i++) begin
            logic busy_e, own_e;
            if (i > 0) @(negedge clk);
            #1;
            busy_e = i[0];
            own_e  = i[1];
            check("rr_s_write", s_write, busy_e);
            check("rr_m0_wait", m0_waitrequest, !(busy_e && !own_e));
            check("rr_m1_wait", m1_waitrequest, !(busy_e && own_e));
            if (busy_e) begin
                check("rr_addr", s_address, own_e ? 23'h0B0 : 23'h0A0);
                check("rr_wdata", s_writedata, own_e ? 32'hBB : 32'hAA);
                check("rr_be", s_byteenable, own_e ? 4'hC : 4'h3);
            end else begin
                check("rr_addr_idle", s_address, 0);
            end
        end
        idle_inputs();

        // stalled m1 write holds the grant against m0
        do_reset();
        @(negedge clk);
        s_waitrequest = 1; m1_write = 1; m1_address = 23'h1B0; #1;
        check("st_c0_s_write", s_write, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_write = 1; m0_address = 23'h0A0; #1;
            check("st_addr", s_address, 23'h1B0);
            check("st_m1_wait", m1_waitrequest, 1);
            check("st_m0_wait", m0_waitrequest, 1);
        end
        @(negedge clk); s_waitrequest = 0; #1;
        check("st_rel_addr", s_address, 23'h1B0);
        check("st_rel_m1_wait", m1_waitrequest, 0);
        @(negedge clk); m1_write = 0; #1;
        check("st_idle_write", s_write, 0);
        @(negedge clk); #1;
        check("st_m0_addr", s_address, 23'h0A0);
        check("st_m0_wait", m0_waitrequest, 0);
        @(negedge clk); m0_write = 0;
        idle_inputs();

        // fill the tag FIFO with m0 reads
        do_reset();
        @(negedge clk); m0_read = 1; m0_address = 23'h040;
        repeat (8) @(negedge clk);
        #1;
        check("full_out4", outstanding, 4);
        check("full_no_read", s_read, 0);
        @(negedge clk); m1_write = 1; m1_address = 23'h077; #1;
        check("full_idle", s_read, 0);
        check("full_m0_wait", m0_waitrequest, 1);
        @(negedge clk); #1;
        check("full_w_grant", s_write, 1);
        check("full_w_addr", s_address, 23'h077);
        check("full_m1_wait", m1_waitrequest, 0);
        @(negedge clk); m1_write = 0; s_readdatavalid = 1; s_readdata = 32'h1234; #1;
        check("full_no_read2", s_read, 0);
        check("full_rdv_m0", m0_readdatavalid, 1);
        @(negedge clk); s_readdatavalid = 0; #1;
        check("full_out3", outstanding, 3);
        check("full_still_idle", s_read, 0);
        @(negedge clk); #1;
        check("full_5th_grant", s_read, 1);
        check("full_5th_wait", m0_waitrequest, 0);
        @(negedge clk); m0_read = 0; #1;
        check("full_out4b", outstanding, 4);
        idle_inputs();

        // steering order m0, m1, m0 with coincident push/pop
        do_reset();
        @(negedge clk); m0_read = 1; m0_address = 23'h010;
        @(negedge clk);
        @(negedge clk); m0_read = 0; m1_read = 1; m1_address = 23'h020;
        @(negedge clk); #1;
        check("ord_m1_grant", s_read, 1);
        check("ord_m1_addr", s_address, 23'h020);
        @(negedge clk); m1_read = 0; m0_read = 1; m0_address = 23'h030;
        s_readdatavalid = 1; s_readdata = 32'h11; #1;
        check("ord_out2", outstanding, 2);
        check("ord_r1_m0", m0_readdatavalid, 1);
        check("ord_r1_m1", m1_readdatavalid, 0);
        @(negedge clk); s_readdata = 32'h22; #1;
        check("ord_acc", s_read && !m0_waitrequest, 1);
        check("ord_r2_m0", m0_readdatavalid, 0);
        check("ord_r2_m1", m1_readdatavalid, 1);
        check("ord_r2_data", m1_readdata, 32'h22);
        check("ord_out1", outstanding, 1);
        @(negedge clk); m0_read = 0; s_readdata = 32'h33; #1;
        check("ord_out1b", outstanding, 1);
        check("ord_r3_m0", m0_readdatavalid, 1);
        check("ord_r3_m1", m1_readdatavalid, 0);
        @(negedge clk); s_readdatavalid = 0; #1;
        check("ord_out0", outstanding, 0);
        check("ord_err", err_rdv, 0);

        // reset with two reads in flight
        do_reset();
        @(negedge clk); m0_read = 1; m0_address = 23'h050;
        @(negedge clk);
        @(negedge clk); m0_read = 0; m1_read = 1; m1_address = 23'h060;
        @(negedge clk);
        @(negedge clk); m1_read = 0; #1;
        check("rr2_out2", outstanding, 2);
        @(negedge clk); reset_n = 0; #1;
        check("ar_out0", outstanding, 0);
        check("ar_s_read", s_read, 0);
        check("ar_m0_wait", m0_waitrequest, 1);
        check("ar_m1_wait", m1_waitrequest, 1);
        @(negedge clk); reset_n = 1;
        @(negedge clk); s_readdatavalid = 1; s_readdata = 32'h55; #1;
        check("ar_m0_rdv", m0_readdatavalid, 0);
        check("ar_m1_rdv", m1_readdatavalid, 0);
        @(negedge clk); s_readdatavalid = 0; #1;
        check("ar_err", err_rdv, 1);
        check("ar_out0b", outstanding, 0);
        @(negedge clk); #1;
        check("ar_err_sticky", err_rdv, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 23: byte/word address width presented to the SDRAM controller slave.
REQ-002 SHALL have parameter DATA_W, default 32: data width, a multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum outstanding reads, a power of two.
REQ-004 SHALL have port clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have, for master i in {0 = instruction cache, 1 = data cache}, the following ports:
- mi_address  in  ADDR_W.
- mi_read  in  1.
- mi_write  in  1.
- mi_writedata  in  DATA_W.
- mi_byteenable  in  BE_W.
- mi_waitrequest  out  1.
- mi_readdata  out  DATA_W.
- mi_readdatavalid  out  1.
REQ-007 SHALL have the following slave-side ports toward the SDRAM controller:
- s_address  out  ADDR_W.
- s_read  out  1.
- s_write  out  1.
- s_writedata  out  DATA_W.
- s_byteenable  out  BE_W.
- s_waitrequest  in  1.
- s_readdata  in  DATA_W.
- s_readdatavalid  in  1.
REQ-008 SHALL have port outstanding  out  log2(MAX_OUT)+1: the current tag FIFO occupancy.
REQ-009 SHALL have port err_rdv  out  1: sticky flag for an unexpected s_readdatavalid.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY, plus a 1-bit owner register and a 1-bit last register.
REQ-011 Request_i SHALL be (mi_write) or (mi_read and outstanding < MAX_OUT).
REQ-012 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-013 In IDLE with any request, the FSM SHALL load owner and enter BUSY on the next edge.
- Single requester: owner = that requester.
- Both requesting: owner = !last (round-robin).
REQ-014 s_address, s_writedata and s_byteenable SHALL equal owner's inputs combinationally in BUSY, and 0 in IDLE.
REQ-015 s_read and s_write SHALL equal owner's read and write combinationally in BUSY, and 0 in IDLE.
REQ-016 mi_waitrequest SHALL be 0 only when state = BUSY, owner = i and s_waitrequest = 0; it SHALL be 1 otherwise, including for the non-owner.
REQ-017 Command acceptance SHALL be state = BUSY, (s_read or s_write) = 1 and s_waitrequest = 0.
REQ-018 On acceptance, last SHALL become owner and the FSM SHALL return to IDLE.
- Minimum spacing between accepted commands: 2 cycles.
REQ-019 The grant SHALL never change while the owner's command is stalled by s_waitrequest; stalls are unbounded.
REQ-020 In BUSY with owner's read = write = 0 (owner withdrew), the FSM SHALL return to IDLE with no acceptance and last unchanged.
REQ-021 On acceptance of a read, the owner id SHALL be pushed into a MAX_OUT-deep tag FIFO; writes SHALL push nothing.
REQ-022 On s_readdatavalid = 1 with the FIFO non-empty, the head SHALL be popped and m[head]_readdatavalid = 1 asserted in that same cycle (combinational, zero latency).
REQ-023 mi_readdata SHALL equal s_readdata for both masters (broadcast); only readdatavalid is steered.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
- Pointers SHALL wrap modulo MAX_OUT.
REQ-025 s_readdatavalid with an empty FIFO SHALL be dropped (no mi_readdatavalid) and set err_rdv = 1 until reset.
REQ-026 With outstanding = MAX_OUT, reads SHALL not be granted.
- Writes SHALL still be granted.
- Occupancy SHALL never exceed MAX_OUT.
REQ-027 outstanding SHALL equal pushes minus pops since reset.

Reset
REQ-028 reset_n = 0 SHALL asynchronously force: state = IDLE, owner = 0, last = 1, FIFO pointers and outstanding = 0, err_rdv = 0.
REQ-029 During reset, all slave-side outputs SHALL be 0, mi_waitrequest = 1 and mi_readdatavalid = 0.
REQ-030 Reset mid-transaction SHALL abandon the in-flight command and discard tags.
- Returning read data after reset SHALL be handled per REQ-025.

Verification
REQ-031 Bench SHALL cover: m0 read at 0x100, s_waitrequest = 0 -> s_read = 1 in cycle 2; m0_waitrequest = 0 in that cycle; outstanding = 1; s_readdatavalid with 0xDEADBEEF -> m0_readdatavalid = 1, m0_readdata = 0xDEADBEEF, outstanding = 0.
REQ-032 Bench SHALL cover: m0 and m1 continuous writes from reset -> grants m0, m1, m0, m1 (last = 1 initially); one acceptance every 2 cycles.
REQ-033 Bench SHALL cover: m1 write, s_waitrequest held 5 cycles with m0 also requesting -> s_address stays m1's for all 5 cycles; m0 is granted only after m1 is accepted.
REQ-034 Bench SHALL cover: 4 m0 reads accepted, none returned -> outstanding = 4; a 5th m0 read is not granted; an m1 write is still granted; one s_readdatavalid -> outstanding = 3 and the 5th read is then granted.
REQ-035 Bench SHALL cover: reads issued m0, m1, m0 -> three returns steer readdatavalid to m0, m1, m0; a return coinciding with a new acceptance keeps order.
REQ-036 Bench SHALL cover: reset with 2 reads outstanding, then s_readdatavalid -> no mi_readdatavalid; err_rdv = 1; outstanding = 0.
